// File: rtl/alu_muldiv_pkg.sv
// Shared op-code header for the execute unit, plus small op classifiers
// used by the top-level control.
package alu_muldiv_pkg;

   typedef enum logic [4:0] {
      ALU_ADD    = 5'h00,
      ALU_SUB    = 5'h01,
      ALU_AND    = 5'h02,
      ALU_OR     = 5'h03,
      ALU_XOR    = 5'h04,
      ALU_SLT    = 5'h05,
      ALU_SLTU   = 5'h06,
      ALU_SLL    = 5'h07,
      ALU_SRL    = 5'h08,
      ALU_SRA    = 5'h09,
      ALU_COPY_B = 5'h0A,
      ALU_XXX    = 5'h0F,
      ALU_MUL    = 5'h10,
      ALU_MULH   = 5'h11,
      ALU_MULHSU = 5'h12,
      ALU_MULHU  = 5'h13,
      ALU_DIV    = 5'h14,
      ALU_DIVU   = 5'h15,
      ALU_REM    = 5'h16,
      ALU_REMU   = 5'h17
   } aluOp_e;

   // M-extension codes occupy 0x10..0x17: bit4 set, bit3 clear
   function automatic logic isIterOp(input logic [4:0] op);
      return op[4] && !op[3];
   endfunction

   // Divide/remainder group is the upper half of the M-extension range
   function automatic logic isDivOp(input logic [4:0] op);
      return isIterOp(op) && op[2];
   endfunction

   function automatic logic isRemOp(input logic [4:0] op);
      return (op == ALU_REM) || (op == ALU_REMU);
   endfunction

   // Operand a is treated as two's complement for these ops
   function automatic logic isSignedA(input logic [4:0] op);
      return (op == ALU_MUL) || (op == ALU_MULH) || (op == ALU_MULHSU) ||
             (op == ALU_DIV) || (op == ALU_REM);
   endfunction

   // Operand b is treated as two's complement for these ops
   function automatic logic isSignedB(input logic [4:0] op);
      return (op == ALU_MUL) || (op == ALU_MULH) ||
             (op == ALU_DIV) || (op == ALU_REM);
   endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Unsigned magnitude datapath: shift-add multiply or restoring divide,
// one bit per step. After WIDTH steps {o_hi,o_lo} is the product, or
// o_lo is the quotient and o_hi the remainder.
module muldiv_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_start,
   input  logic             i_step,
   input  logic             i_isDiv,
   input  logic [WIDTH-1:0] i_opA,
   input  logic [WIDTH-1:0] i_opB,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo
);

   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic [WIDTH-1:0] r_opB;
   logic             r_isDiv;

   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_shifted;
   logic [WIDTH:0]   w_trial;

   // Candidate next values for both algorithms; carry/borrow kept in bit WIDTH
   always_comb begin
      w_sum     = {1'b0, r_hi} + {1'b0, r_opB};
      w_shifted = {r_hi, r_lo[WIDTH-1]};
      w_trial   = w_shifted - {1'b0, r_opB};
   end

   // Load magnitudes on start, then advance one bit per step
   always_ff @(posedge clk) begin
      if (reset) begin
         r_hi    <= '0;
         r_lo    <= '0;
         r_opB   <= '0;
         r_isDiv <= 1'b0;
      end else if (i_start) begin
         r_hi    <= '0;
         r_lo    <= i_opA;
         r_opB   <= i_opB;
         r_isDiv <= i_isDiv;
      end else if (i_step) begin
         if (r_isDiv) begin
            if (!w_trial[WIDTH]) begin
               r_hi <= w_trial[WIDTH-1:0];
               r_lo <= {r_lo[WIDTH-2:0], 1'b1};
            end else begin
               r_hi <= w_shifted[WIDTH-1:0];
               r_lo <= {r_lo[WIDTH-2:0], 1'b0};
            end
         end else begin
            if (r_lo[0]) begin
               {r_hi, r_lo} <= {w_sum, r_lo[WIDTH-1:1]};
            end else begin
               {r_hi, r_lo} <= {1'b0, r_hi, r_lo[WIDTH-1:1]};
            end
         end
      end
   end

   assign o_hi = r_hi;
   assign o_lo = r_lo;

endmodule

// File: rtl/alu_muldiv.sv
// Handshaked execute unit: registered single-cycle ALU ops plus iterative
// RV32M multiply/divide. One operation in flight; the result sits in an
// output register until the consumer takes it.
module alu_muldiv
   import alu_muldiv_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             busy
);

   localparam int               CNT_W    = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MIN_INT  = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ITER = 2'd1,
      S_FIX  = 2'd2
   } state_e;

   state_e             r_state;
   state_e             w_nextState;
   logic [CNT_W-1:0]   r_count;
   logic [4:0]         r_op;
   logic               r_negRes;
   logic               r_negRem;
   logic               r_outValid;
   logic [WIDTH-1:0]   r_result;

   logic               w_inReady;
   logic               w_accept;
   logic               w_startIter;
   logic               w_iterStep;
   logic               w_fixDone;
   logic               w_busy;
   logic               w_oneCycle;
   logic               w_special;
   logic [WIDTH-1:0]   w_quick;
   logic [WIDTH-1:0]   w_specialVal;
   logic [WIDTH-1:0]   w_magA;
   logic [WIDTH-1:0]   w_magB;
   logic               w_negA;
   logic               w_negB;
   logic [WIDTH-1:0]   w_iterHi;
   logic [WIDTH-1:0]   w_iterLo;
   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0]   w_fixVal;

   // Single-cycle ALU results; undefined codes (including XXX) yield zero
   always_comb begin
      w_quick = '0;
      case (op)
         ALU_ADD:    w_quick = a + b;
         ALU_SUB:    w_quick = a - b;
         ALU_AND:    w_quick = a & b;
         ALU_OR:     w_quick = a | b;
         ALU_XOR:    w_quick = a ^ b;
         ALU_SLT:    w_quick = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
         ALU_SLTU:   w_quick = {{(WIDTH-1){1'b0}}, a < b};
         ALU_SLL:    w_quick = a << b[SHAMT_W-1:0];
         ALU_SRL:    w_quick = a >> b[SHAMT_W-1:0];
         ALU_SRA:    w_quick = $signed(a) >>> b[SHAMT_W-1:0];
         ALU_COPY_B: w_quick = b;
         default:    w_quick = '0;
      endcase
   end

   // Divide-by-zero and signed overflow finish immediately without iterating;
   // sign flags and magnitudes feed the iterative datapath otherwise
   always_comb begin
      w_special    = 1'b0;
      w_specialVal = '0;
      if (isDivOp(op)) begin
         if (b == '0) begin
            w_special    = 1'b1;
            w_specialVal = isRemOp(op) ? a : '1;
         end else if (isSignedA(op) && (a == MIN_INT) && (b == '1)) begin
            w_special    = 1'b1;
            w_specialVal = isRemOp(op) ? '0 : MIN_INT;
         end
      end
      w_oneCycle = !isIterOp(op) || w_special;
      w_negA     = isSignedA(op) && a[WIDTH-1];
      w_negB     = isSignedB(op) && b[WIDTH-1];
      w_magA     = w_negA ? -a : a;
      w_magB     = w_negB ? -b : b;
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next state, handshake and datapath strobes
   always_comb begin
      w_nextState = r_state;
      w_inReady   = 1'b0;
      w_accept    = 1'b0;
      w_startIter = 1'b0;
      w_iterStep  = 1'b0;
      w_fixDone   = 1'b0;
      w_busy      = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_inReady = !r_outValid || out_ready;
            w_accept  = in_valid && w_inReady;
            if (w_accept && !w_oneCycle) begin
               w_startIter = 1'b1;
               w_nextState = S_ITER;
            end
         end
         S_ITER: begin
            w_busy     = 1'b1;
            w_iterStep = 1'b1;
            if (r_count == LAST_CNT) begin
               w_nextState = S_FIX;
            end
         end
         S_FIX: begin
            w_busy      = 1'b1;
            w_fixDone   = 1'b1;
            w_nextState = S_IDLE;
         end
         default: w_nextState = S_IDLE;
      endcase
   end

   // Latch op and result signs at accept; count iteration steps
   always_ff @(posedge clk) begin
      if (reset) begin
         r_op     <= '0;
         r_negRes <= 1'b0;
         r_negRem <= 1'b0;
         r_count  <= '0;
      end else if (w_startIter) begin
         r_op     <= op;
         r_negRes <= w_negA ^ w_negB;
         r_negRem <= w_negA;
         r_count  <= '0;
      end else if (w_iterStep) begin
         r_count  <= r_count + 1'b1;
      end
   end

   muldiv_iter #(
      .WIDTH (WIDTH)
   ) u_iter (
      .clk     (clk),
      .reset   (reset),
      .i_start (w_startIter),
      .i_step  (w_iterStep),
      .i_isDiv (isDivOp(op)),
      .i_opA   (w_magA),
      .i_opB   (w_magB),
      .o_hi    (w_iterHi),
      .o_lo    (w_iterLo)
   );

   // Re-apply signs to the magnitude results and pick the requested half
   always_comb begin
      w_prod   = {w_iterHi, w_iterLo};
      w_fixVal = '0;
      if (r_negRes) begin
         w_prod = -w_prod;
      end
      case (r_op)
         ALU_MUL:    w_fixVal = w_prod[WIDTH-1:0];
         ALU_MULH,
         ALU_MULHSU,
         ALU_MULHU:  w_fixVal = w_prod[2*WIDTH-1:WIDTH];
         ALU_DIV,
         ALU_DIVU:   w_fixVal = r_negRes ? -w_iterLo : w_iterLo;
         ALU_REM,
         ALU_REMU:   w_fixVal = r_negRem ? -w_iterHi : w_iterHi;
         default:    w_fixVal = '0;
      endcase
   end

   // Output register: load on completion, drop valid once consumed
   always_ff @(posedge clk) begin
      if (reset) begin
         r_outValid <= 1'b0;
         r_result   <= '0;
      end else if (w_accept && w_oneCycle) begin
         r_outValid <= 1'b1;
         r_result   <= w_special ? w_specialVal : w_quick;
      end else if (w_fixDone) begin
         r_outValid <= 1'b1;
         r_result   <= w_fixVal;
      end else if (out_ready) begin
         r_outValid <= 1'b0;
      end
   end

   assign in_ready  = w_inReady;
   assign out_valid = r_outValid;
   assign result    = r_result;
   assign busy      = w_busy;

endmodule
